mac_stream_feeder: RTL

- Transmit-side front end for `MAC_array`.
- Accepts a serial stream of 64-bit operand words from the DMA read path (valid/ready) and packs each group of four words into one 256-bit beat.
- Drives the array's four `DMA_channel` inputs together with `en`, `clr`, `bias` and `read_en`.
- Sequences one complete dot product per `start` command and returns the captured `dot_product` as `result`.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_stream_feeder_beat_packer.sv | 38 +++
 rtl/mac_stream_feeder.sv | 119 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and FSM state type for the MAC stream feeder
package mac_pkg;
    localparam int DATA_W  = 64;
    localparam int LEN_W   = 16;
    localparam int RES_W   = 16;
    localparam int NUM_CH  = 4;
    localparam int MAC_LAT = 2;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATHER,
        ST_DRAIN,
        ST_READ,
        ST_DONE
    } feeder_state_t;
endpackage

// File: rtl/mac_stream_feeder_beat_packer.sv
// beat_packer: packs four consecutive stream words into one beat of channel registers
module beat_packer #(
    parameter int DATA_W = mac_pkg::DATA_W
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      accept_i,
    input  logic [DATA_W-1:0]                         data_i,
    output logic                                      beat_done_o,
    output logic                                      mac_en_o,
    output logic [mac_pkg::NUM_CH-1:0][DATA_W-1:0]    ch_o
);
    import mac_pkg::*;

    logic [1:0]                    widx_q;
    logic [NUM_CH-2:0][DATA_W-1:0] stage_q;

    assign beat_done_o = accept_i && (widx_q == 2'(NUM_CH - 1));

    // Stage the first three words; the fourth goes straight to channel 3 with the staged ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            widx_q   <= '0;
            stage_q  <= '0;
            ch_o     <= '0;
            mac_en_o <= 1'b0;
        end else begin
            mac_en_o <= beat_done_o;
            if (accept_i)
                widx_q <= widx_q + 2'd1;
            for (int i = 0; i < NUM_CH - 1; i++)
                if (accept_i && widx_q == 2'(i))
                    stage_q[i] <= data_i;
            if (beat_done_o)
                ch_o <= {data_i, stage_q};
        end
    end
endmodule

// File: rtl/mac_stream_feeder.sv
// mac_stream_feeder: feeds packed operand beats to the MAC array and returns its dot product
module mac_stream_feeder #(
    parameter int DATA_W  = mac_pkg::DATA_W,
    parameter int LEN_W   = mac_pkg::LEN_W,
    parameter int RES_W   = mac_pkg::RES_W,
    parameter int MAC_LAT = mac_pkg::MAC_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [RES_W-1:0]  bias_in,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] DMA_channel_0,
    output logic [DATA_W-1:0] DMA_channel_1,
    output logic [DATA_W-1:0] DMA_channel_2,
    output logic [DATA_W-1:0] DMA_channel_3,
    output logic              mac_en,
    output logic              mac_clr,
    output logic [RES_W-1:0]  mac_bias,
    output logic              mac_read_en,
    input  logic [RES_W-1:0]  mac_dot_product,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    output logic              busy
);
    import mac_pkg::*;

    localparam int CNT_W = $clog2(MAC_LAT + 1);

    feeder_state_t                 state_q, state_d;
    logic [LEN_W-1:0]              beats_q, beats_d;
    logic [CNT_W-1:0]              drain_q, drain_d;
    logic [RES_W-1:0]              bias_q, bias_d;
    logic [RES_W-1:0]              result_q, result_d;
    logic                          accept;
    logic                          beat_done;
    logic [NUM_CH-1:0][DATA_W-1:0] ch;

    assign s_ready       = state_q == ST_GATHER;
    assign accept        = s_valid && s_ready;
    assign mac_clr       = state_q == ST_CLEAR;
    assign mac_read_en   = state_q == ST_READ;
    assign result_valid  = state_q == ST_DONE;
    assign busy          = state_q != ST_IDLE;
    assign mac_bias      = bias_q;
    assign result        = result_q;
    assign DMA_channel_0 = ch[0];
    assign DMA_channel_1 = ch[1];
    assign DMA_channel_2 = ch[2];
    assign DMA_channel_3 = ch[3];

    beat_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept_i   (accept),
        .data_i     (s_data),
        .beat_done_o(beat_done),
        .mac_en_o   (mac_en),
        .ch_o       (ch)
    );

    // Command sequencing: clear, gather N beats, wait for the array pipeline, read, report
    always_comb begin
        state_d  = state_q;
        beats_d  = beats_q;
        drain_d  = drain_q;
        bias_d   = bias_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    beats_d = vec_len;
                    bias_d  = bias_in;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                drain_d = CNT_W'(MAC_LAT - 1);
                state_d = beats_q != '0 ? ST_GATHER : ST_DRAIN;
            end
            ST_GATHER: begin
                if (beat_done) begin
                    beats_d = beats_q - LEN_W'(1);
                    state_d = beats_q == LEN_W'(1) ? ST_DRAIN : ST_GATHER;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - CNT_W'(1);
                state_d = drain_q == '0 ? ST_READ : ST_DRAIN;
            end
            ST_READ: begin
                result_d = mac_dot_product;
                state_d  = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, counters, bias and captured result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            beats_q  <= '0;
            drain_q  <= '0;
            bias_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            beats_q  <= beats_d;
            drain_q  <= drain_d;
            bias_q   <= bias_d;
            result_q <= result_d;
        end
    end
endmodule
